// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals around the shared line memory port.
// The slave modport is the arbiter's view; master is the caches-plus-memory view.
interface mem_arbiter_if #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned LINE_SIZE = 128
);
   logic                 ic_mem_req;
   logic [WORD_SIZE-1:0] ic_mem_req_addr;
   logic                 ic_mem_res;
   logic [WORD_SIZE-1:0] ic_mem_res_addr;
   logic [LINE_SIZE-1:0] ic_mem_res_data;

   logic                 dc_mem_req;
   logic [WORD_SIZE-1:0] dc_mem_req_addr;
   logic                 dc_mem_write;
   logic [WORD_SIZE-1:0] dc_mem_write_addr;
   logic [LINE_SIZE-1:0] dc_mem_write_data;
   logic                 dc_mem_write_ack;
   logic                 dc_mem_res;
   logic [WORD_SIZE-1:0] dc_mem_res_addr;
   logic [LINE_SIZE-1:0] dc_mem_res_data;

   logic                 mem_req;
   logic [WORD_SIZE-1:0] mem_req_addr;
   logic                 mem_write;
   logic [WORD_SIZE-1:0] mem_write_addr;
   logic [LINE_SIZE-1:0] mem_write_data;
   logic                 mem_res;
   logic [WORD_SIZE-1:0] mem_res_addr;
   logic [LINE_SIZE-1:0] mem_res_data;

   logic                 busy;

   modport slave (
      input  ic_mem_req, ic_mem_req_addr,
      output ic_mem_res, ic_mem_res_addr, ic_mem_res_data,
      input  dc_mem_req, dc_mem_req_addr,
      input  dc_mem_write, dc_mem_write_addr, dc_mem_write_data,
      output dc_mem_write_ack, dc_mem_res, dc_mem_res_addr, dc_mem_res_data,
      output mem_req, mem_req_addr, mem_write, mem_write_addr, mem_write_data,
      input  mem_res, mem_res_addr, mem_res_data,
      output busy
   );

   modport master (
      output ic_mem_req, ic_mem_req_addr,
      input  ic_mem_res, ic_mem_res_addr, ic_mem_res_data,
      output dc_mem_req, dc_mem_req_addr,
      output dc_mem_write, dc_mem_write_addr, dc_mem_write_data,
      input  dc_mem_write_ack, dc_mem_res, dc_mem_res_addr, dc_mem_res_data,
      input  mem_req, mem_req_addr, mem_write, mem_write_addr, mem_write_data,
      output mem_res, mem_res_addr, mem_res_data,
      input  busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single line memory port between icache reads and dcache reads/write-backs.
// One read outstanding at a time; write-backs win in IDLE; competing reads alternate.
module mem_arbiter #(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned LINE_SIZE = 128
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      WAIT
   } state_t;

   typedef enum logic {
      SIDE_IC,
      SIDE_DC
   } side_t;

   state_t state;
   side_t  owner;
   side_t  rr_prio;
   logic   grant_dc_c;
   logic   res_hit_c;

   // dcache wins a read grant when alone or when the tie-break favours it
   assign grant_dc_c = bus.dc_mem_req & (~bus.ic_mem_req | (rr_prio == SIDE_DC));

   // A response counts only for the address we issued; stale or foreign ones are dropped
   assign res_hit_c = (state == WAIT) & bus.mem_res & (bus.mem_res_addr == bus.mem_req_addr);

   assign bus.ic_mem_res      = res_hit_c & (owner == SIDE_IC);
   assign bus.dc_mem_res      = res_hit_c & (owner == SIDE_DC);
   assign bus.ic_mem_res_addr = bus.mem_res_addr;
   assign bus.ic_mem_res_data = bus.mem_res_data;
   assign bus.dc_mem_res_addr = bus.mem_res_addr;
   assign bus.dc_mem_res_data = bus.mem_res_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         owner                <= SIDE_IC;
         rr_prio              <= SIDE_IC;
         bus.mem_req          <= 1'b0;
         bus.mem_req_addr     <= WORD_SIZE'(0);
         bus.mem_write        <= 1'b0;
         bus.mem_write_addr   <= WORD_SIZE'(0);
         bus.mem_write_data   <= LINE_SIZE'(0);
         bus.dc_mem_write_ack <= 1'b0;
         bus.busy             <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.dc_mem_write) begin
                  bus.mem_write        <= 1'b1;
                  bus.mem_write_addr   <= bus.dc_mem_write_addr;
                  bus.mem_write_data   <= bus.dc_mem_write_data;
                  bus.dc_mem_write_ack <= 1'b1;
                  state                <= WRITE;
                  bus.busy             <= 1'b1;
               end else if (bus.ic_mem_req | bus.dc_mem_req) begin
                  bus.mem_req      <= 1'b1;
                  bus.mem_req_addr <= grant_dc_c ? bus.dc_mem_req_addr : bus.ic_mem_req_addr;
                  owner            <= grant_dc_c ? SIDE_DC : SIDE_IC;
                  rr_prio          <= grant_dc_c ? SIDE_IC : SIDE_DC;
                  state            <= WAIT;
                  bus.busy         <= 1'b1;
               end
            end
            WRITE: begin
               bus.mem_write        <= 1'b0;
               bus.dc_mem_write_ack <= 1'b0;
               state                <= IDLE;
               bus.busy             <= 1'b0;
            end
            WAIT: begin
               // mem_req_addr stays latched for response matching
               bus.mem_req <= 1'b0;
               if (res_hit_c) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table for read arbitration,
// hand sequences for write priority, address filtering and reset abandonment.
module tb_mem_arbiter;

   localparam int unsigned WORD_SIZE = 32;
   localparam int unsigned LINE_SIZE = 128;

   typedef struct {
      logic                 is_dc;
      logic [WORD_SIZE-1:0] addr;
      logic [LINE_SIZE-1:0] data;
   } exp_t;

   typedef struct {
      logic                 ic;
      logic [WORD_SIZE-1:0] ica;
      logic                 dc;
      logic [WORD_SIZE-1:0] dca;
      logic                 exp_dc;
      logic [WORD_SIZE-1:0] exp_a;
   } vec_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb[$];

   mem_arbiter_if #(.WORD_SIZE(WORD_SIZE), .LINE_SIZE(LINE_SIZE)) bus ();

   mem_arbiter #(.WORD_SIZE(WORD_SIZE), .LINE_SIZE(LINE_SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // {mem_req, mem_write, dc_mem_write_ack, busy}
   task automatic chk_ctl(input string name, input logic [3:0] exp);
      chk(name, 128'({bus.mem_req, bus.mem_write, bus.dc_mem_write_ack, bus.busy}), 128'(exp));
   endtask

   function automatic logic [LINE_SIZE-1:0] line_of(input logic [WORD_SIZE-1:0] a);
      return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0FF_EE00 + a};
   endfunction

   // Memory answers in the current cycle; the expected owner is queued when a hit is expected
   task automatic respond(input logic [WORD_SIZE-1:0] a, input logic [LINE_SIZE-1:0] d,
                          input logic expect_hit, input logic exp_dc);
      step();
      bus.mem_res      = 1'b1;
      bus.mem_res_addr = a;
      bus.mem_res_data = d;
      if (expect_hit) sb.push_back('{exp_dc, a, d});
      #3;
      if (expect_hit) begin
         chk("strobe_seen", 128'(sb.size()), 128'(0));
         sb.delete();
         if (exp_dc) bus.dc_mem_req = 1'b0;
         else        bus.ic_mem_req = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.mem_res = 1'b0;
   endtask

   task automatic do_reset();
      step();
      rst                   = 1'b1;
      bus.ic_mem_req        = 1'b0;
      bus.ic_mem_req_addr   = '0;
      bus.dc_mem_req        = 1'b0;
      bus.dc_mem_req_addr   = '0;
      bus.dc_mem_write      = 1'b0;
      bus.dc_mem_write_addr = '0;
      bus.dc_mem_write_data = '0;
      bus.mem_res           = 1'b0;
      bus.mem_res_addr      = '0;
      bus.mem_res_data      = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Response monitor: every strobe must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (bus.ic_mem_res && bus.dc_mem_res) begin
            total++;
            bad++;
            $display("FAIL both_strobes ic=1 dc=1 required at most one");
         end else if (bus.ic_mem_res || bus.dc_mem_res) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_strobe ic=%0b dc=%0b addr=%h required no strobe",
                        bus.ic_mem_res, bus.dc_mem_res, bus.mem_res_addr);
            end else begin
               e = sb.pop_front();
               chk("res_owner_dc", 128'(bus.dc_mem_res), 128'(e.is_dc));
               chk("res_addr", 128'(e.is_dc ? bus.dc_mem_res_addr : bus.ic_mem_res_addr), 128'(e.addr));
               chk("res_data", e.is_dc ? bus.dc_mem_res_data : bus.ic_mem_res_data, e.data);
            end
         end
      end
   end

   initial begin
      vec_t vt[10];
      total = 0;
      bad   = 0;
      rst   = 1'b1;

      vt[0] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100};
      vt[1] = '{1'b0, 32'h000, 1'b1, 32'h200, 1'b1, 32'h200};
      vt[2] = '{1'b1, 32'h110, 1'b1, 32'h210, 1'b0, 32'h110};
      vt[3] = '{1'b0, 32'h000, 1'b1, 32'h210, 1'b1, 32'h210};
      vt[4] = '{1'b1, 32'h120, 1'b0, 32'h000, 1'b0, 32'h120};
      vt[5] = '{1'b1, 32'h130, 1'b1, 32'h220, 1'b1, 32'h220};
      vt[6] = '{1'b1, 32'h130, 1'b0, 32'h000, 1'b0, 32'h130};
      vt[7] = '{1'b0, 32'h000, 1'b1, 32'h230, 1'b1, 32'h230};
      vt[8] = '{1'b1, 32'h140, 1'b1, 32'h240, 1'b0, 32'h140};
      vt[9] = '{1'b0, 32'h000, 1'b1, 32'h240, 1'b1, 32'h240};

      // Reset then idle
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step();
         #1;
         chk_ctl("idle_ctl", 4'b0000);
      end
      chk("idle_req_addr", 128'(bus.mem_req_addr), 128'(0));
      chk("idle_wr_addr", 128'(bus.mem_write_addr), 128'(0));
      chk("idle_wr_data", bus.mem_write_data, 128'(0));
      respond(32'h0, line_of(32'h0), 1'b0, 1'b0);
      step();
      #1;
      chk_ctl("idle_after_res", 4'b0000);

      // Single uncontested icache read with a late answer
      step();
      bus.ic_mem_req      = 1'b1;
      bus.ic_mem_req_addr = 32'h0000_1000;
      #1;
      chk_ctl("ic_req_cycle", 4'b0000);
      step();
      #1;
      chk_ctl("ic_issue", 4'b1001);
      chk("ic_issue_addr", 128'(bus.mem_req_addr), 128'(32'h1000));
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         chk_ctl("ic_wait", 4'b0001);
      end
      respond(32'h1000, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0);
      step();
      #1;
      chk_ctl("ic_done", 4'b0000);

      // Round-robin table, starting from a fresh tie-break
      do_reset();
      for (int v = 0; v < 10; v++) begin
         step();
         bus.ic_mem_req      = vt[v].ic;
         bus.ic_mem_req_addr = vt[v].ica;
         bus.dc_mem_req      = vt[v].dc;
         bus.dc_mem_req_addr = vt[v].dca;
         #1;
         chk_ctl("rr_idle", 4'b0000);
         step();
         #1;
         chk_ctl("rr_issue", 4'b1001);
         chk("rr_grant_addr", 128'(bus.mem_req_addr), 128'(vt[v].exp_a));
         step();
         #1;
         chk_ctl("rr_pulse", 4'b0001);
         respond(vt[v].exp_a, line_of(vt[v].exp_a), 1'b1, vt[v].exp_dc);
      end

      // Write-back beats a simultaneous read of the same line
      step();
      bus.dc_mem_write      = 1'b1;
      bus.dc_mem_write_addr = 32'h300;
      bus.dc_mem_write_data = line_of(32'h3030);
      bus.dc_mem_req        = 1'b1;
      bus.dc_mem_req_addr   = 32'h300;
      step();
      #1;
      chk_ctl("wr_cmd", 4'b0111);
      chk("wr_addr", 128'(bus.mem_write_addr), 128'(32'h300));
      chk("wr_data", bus.mem_write_data, line_of(32'h3030));
      bus.dc_mem_write = 1'b0;
      step();
      #1;
      chk_ctl("wr_idle", 4'b0000);
      step();
      #1;
      chk_ctl("wr_then_read", 4'b1001);
      chk("wr_then_read_addr", 128'(bus.mem_req_addr), 128'(32'h300));
      step();
      #1;
      chk_ctl("wr_then_wait", 4'b0001);
      respond(32'h300, line_of(32'h300), 1'b1, 1'b1);

      // Foreign response ignored; write-back held off until IDLE
      step();
      bus.ic_mem_req      = 1'b1;
      bus.ic_mem_req_addr = 32'h400;
      step();
      #1;
      chk_ctl("flt_issue", 4'b1001);
      step();
      bus.dc_mem_write      = 1'b1;
      bus.dc_mem_write_addr = 32'h4C0;
      bus.dc_mem_write_data = line_of(32'h4C0);
      #1;
      chk_ctl("flt_wait", 4'b0001);
      step();
      #1;
      chk_ctl("flt_wr_held", 4'b0001);
      respond(32'h500, line_of(32'h500), 1'b0, 1'b0);
      step();
      #1;
      chk_ctl("flt_still_busy", 4'b0001);
      respond(32'h400, line_of(32'h400), 1'b1, 1'b0);
      step();
      #1;
      chk_ctl("flt_idle", 4'b0000);
      step();
      #1;
      chk_ctl("flt_wr_cmd", 4'b0111);
      chk("flt_wr_addr", 128'(bus.mem_write_addr), 128'(32'h4C0));
      bus.dc_mem_write = 1'b0;
      step();
      #1;
      chk_ctl("flt_wr_done", 4'b0000);

      // Reset during WAIT abandons the read; late answer dropped, request reissued
      step();
      bus.ic_mem_req      = 1'b1;
      bus.ic_mem_req_addr = 32'h600;
      step();
      #1;
      chk_ctl("rst_issue", 4'b1001);
      step();
      rst = 1'b1;
      #1;
      chk_ctl("rst_wait", 4'b0001);
      step();
      rst              = 1'b0;
      bus.mem_res      = 1'b1;
      bus.mem_res_addr = 32'h600;
      bus.mem_res_data = line_of(32'h600);
      #1;
      chk_ctl("rst_idle", 4'b0000);
      chk("rst_req_addr", 128'(bus.mem_req_addr), 128'(0));
      @(posedge clk);
      #1;
      bus.mem_res = 1'b0;
      step();
      #1;
      chk_ctl("rst_reissue", 4'b1001);
      chk("rst_reissue_addr", 128'(bus.mem_req_addr), 128'(32'h600));
      step();
      #1;
      chk_ctl("rst_rewait", 4'b0001);
      respond(32'h600, line_of(32'h6600), 1'b1, 1'b0);
      step();
      #1;
      chk_ctl("rst_done", 4'b0000);

      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single line-granular memory port between the instruction cache (reads only) and the data cache (line reads and dirty-line write-backs).
- Sits between both caches and main memory.
- Serialises traffic with at most one read outstanding, gives write-backs priority, and round-robins competing reads.
- Routes each memory response only to the cache that issued the request.

Parameters:
- WORD_SIZE, `WORD_SIZE (32): address width.
- LINE_SIZE, `CACHE_LINE_SIZE (128): line data width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- ic_mem_req  input  1  icache line-read request, level, held until ic_mem_res
- ic_mem_req_addr  input  WORD_SIZE  icache request address
- ic_mem_res  output  1  one-cycle response strobe to icache
- ic_mem_res_addr  output  WORD_SIZE  mem_res_addr pass-through
- ic_mem_res_data  output  LINE_SIZE  mem_res_data pass-through
- dc_mem_req  input  1  dcache line-read request, level, held until dc_mem_res
- dc_mem_req_addr  input  WORD_SIZE  dcache read address
- dc_mem_write  input  1  dcache write-back request, level, held until dc_mem_write_ack
- dc_mem_write_addr  input  WORD_SIZE  write-back address
- dc_mem_write_data  input  LINE_SIZE  write-back line
- dc_mem_write_ack  output  1  one-cycle write accepted strobe
- dc_mem_res  output  1  one-cycle response strobe to dcache
- dc_mem_res_addr  output  WORD_SIZE  mem_res_addr pass-through
- dc_mem_res_data  output  LINE_SIZE  mem_res_data pass-through
- mem_req  output  1  registered one-cycle read command to memory
- mem_req_addr  output  WORD_SIZE  registered read address
- mem_write  output  1  registered one-cycle write command
- mem_write_addr  output  WORD_SIZE  registered write address
- mem_write_data  output  LINE_SIZE  registered write line
- mem_res  input  1  memory response strobe
- mem_res_addr  input  WORD_SIZE  response address
- mem_res_data  input  LINE_SIZE  response line
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst high at an edge) sets:
  - state=IDLE, owner=IC, rr_prio=IC.
  - mem_req=0, mem_write=0, dc_mem_write_ack=0.
  - mem_req_addr, mem_write_addr and mem_write_data all 0.
- Reset mid-transaction abandons the transaction. A late mem_res after reset is ignored because state is IDLE.
- States:
  - IDLE: no transaction.
  - WRITE: one cycle; mem_write pulse and ack visible.
  - WAIT: read issued, waiting for its response.
- IDLE decision, evaluated in the cycle and committed at the edge:
  - dc_mem_write high: register mem_write=1, mem_write_addr/data from the dcache, dc_mem_write_ack=1; go to WRITE. Writes beat any read.
  - Otherwise, if one read request is high: grant it.
  - Otherwise, if both read requests are high: grant rr_prio.
  - On a read grant: register mem_req=1, mem_req_addr, owner; flip rr_prio to the non-granted side; go to WAIT.
- WRITE: mem_write and dc_mem_write_ack are cleared at the next edge; go to IDLE.
- WAIT:
  - mem_req is cleared at the next edge, so it is a single-cycle pulse.
  - A response is accepted only if mem_res=1 and mem_res_addr == mem_req_addr (latched).
  - On acceptance, ic_mem_res or dc_mem_res (selected by owner) is driven combinationally in the same cycle; the other strobe stays 0. Go to IDLE at the edge.
  - A mem_res with a mismatching address is ignored: no strobe, stay in WAIT.
  - dc_mem_write arriving during WAIT is held off until IDLE.
- Res strobes are 0 outside WAIT. Res addr/data outputs are unconditional pass-throughs.
- Requester contract: a requester deasserts its request at the edge where it sees its ack or res strobe. The arbiter never reissues a serviced request.
- Latency:
  - Uncontested read request seen in cycle N: mem_req high in cycle N+1.
  - Minimum back-to-back spacing: a new grant is possible in the cycle after the response (IDLE again).
  - Write: ack and mem_write both high in cycle N+1; the next grant is decided in cycle N+2.
- No address arithmetic; all widths pass through unchanged.

Test Plan:
- Reset then idle: all outputs 0, busy=0 for 10 cycles. Inject mem_res=1 while IDLE → no ic/dc strobe.
- icache read 0x0000_1000 in cycle 2 → mem_req=1 with addr 0x1000 only in cycle 3. Memory answers in cycle 7 with data 0xDEAD…BEEF → ic_mem_res=1 in cycle 7, dc_mem_res=0, busy=0 in cycle 8.
- ic and dc read both asserted after reset (addr 0x100 / 0x200) → icache granted first. After its response, the dcache is granted next (mem_req_addr=0x200). A repeated tie then grants icache again.
- dc_mem_write 0x300 plus dc_mem_req 0x300 asserted together → mem_write and ack in cycle N+1; mem_req 0x300 issued in cycle N+3, after WRITE and IDLE.
- In WAIT for 0x400, mem_res with addr 0x500 → no strobe, busy stays 1. A later mem_res with addr 0x400 → owner strobe.
- rst pulsed during WAIT → state IDLE, mem_req=0. The late response produces no strobe, and a pending request is reissued.
